// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one memory bus between an instruction-fetch master (IF, read only)
//   and a data-memory master (DM, read/write). Only one access is in flight at
//   any time. Every output is driven directly from a register.
//
//   Access sequence:
//     IDLE    -> pick a master and register the bus command with bus_req=1
//     IF_BUS  -> hold the command until bus_ack arrives or the wait runs out
//     DM_BUS  -> same as IF_BUS, for the data master
//     DONE    -> one-cycle ready pulse to the granted master, then back to IDLE
//
//   When both masters request in the same IDLE cycle, the master that was not
//   granted last wins. After reset last_grant points at IF, so DM wins the
//   first tie.
//
// Parameters:
//   TIMEOUT    bus cycles waited for bus_ack before the access is aborted
//              (1..255)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   if_req     fetch request, held until if_ready
//   if_addr    fetch address, stable while if_req is high
//   if_rdata   fetch read data, valid while if_ready is high
//   if_ready   one-cycle fetch completion pulse
//   dm_req     data request, held until dm_ready
//   dm_we      data access is a write
//   dm_sel     data byte enables
//   dm_addr    data address
//   dm_wdata   data write data
//   dm_rdata   data read data, valid while dm_ready is high
//   dm_ready   one-cycle data completion pulse
//   bus_req    bus request, high for the whole bus phase
//   bus_we     registered bus command: write enable
//   bus_sel    registered bus command: byte enables
//   bus_addr   registered bus command: address
//   bus_wdata  registered bus command: write data
//   bus_rdata  bus read data, valid while bus_ack is high
//   bus_ack    one-cycle bus completion
//   bus_err    high together with the ready pulse when the access timed out
//   busy       high whenever the arbiter is not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_sel,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,

    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,

    output logic        bus_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_BUS = 2'd1,
        DM_BUS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Encoding of the last_grant register.
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    // The wait counter starts at 0 on grant. When it already holds
    // TIMEOUT-1 and another bus cycle passes without bus_ack, that is the
    // TIMEOUT-th empty cycle and the access is aborted.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_t      state_reg,      state_next;
    logic        last_grant_reg, last_grant_next;
    logic [7:0]  wait_cnt_reg,   wait_cnt_next;

    logic        bus_req_reg,    bus_req_next;
    logic        bus_we_reg,     bus_we_next;
    logic [3:0]  bus_sel_reg,    bus_sel_next;
    logic [31:0] bus_addr_reg,   bus_addr_next;
    logic [31:0] bus_wdata_reg,  bus_wdata_next;

    logic [31:0] if_rdata_reg,   if_rdata_next;
    logic        if_ready_reg,   if_ready_next;
    logic [31:0] dm_rdata_reg,   dm_rdata_next;
    logic        dm_ready_reg,   dm_ready_next;
    logic        bus_err_reg,    bus_err_next;
    logic        busy_reg,       busy_next;

    // Arbitration decision, only used in IDLE.
    logic        grant_dm;
    // The access in flight belongs to the data master.
    logic        serving_dm;
    // The current bus cycle is the last one before the abort.
    logic        wait_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= GRANT_IF;
            wait_cnt_reg   <= 8'd0;
            bus_req_reg    <= 1'b0;
            bus_we_reg     <= 1'b0;
            bus_sel_reg    <= 4'd0;
            bus_addr_reg   <= 32'd0;
            bus_wdata_reg  <= 32'd0;
            if_rdata_reg   <= 32'd0;
            if_ready_reg   <= 1'b0;
            dm_rdata_reg   <= 32'd0;
            dm_ready_reg   <= 1'b0;
            bus_err_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            wait_cnt_reg   <= wait_cnt_next;
            bus_req_reg    <= bus_req_next;
            bus_we_reg     <= bus_we_next;
            bus_sel_reg    <= bus_sel_next;
            bus_addr_reg   <= bus_addr_next;
            bus_wdata_reg  <= bus_wdata_next;
            if_rdata_reg   <= if_rdata_next;
            if_ready_reg   <= if_ready_next;
            dm_rdata_reg   <= dm_rdata_next;
            dm_ready_reg   <= dm_ready_next;
            bus_err_reg    <= bus_err_next;
            busy_reg       <= busy_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Everything holds by default. The ready pulses and bus_err are
        // single-cycle and fall back to 0 unless set below.
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        wait_cnt_next   = wait_cnt_reg;
        bus_req_next    = bus_req_reg;
        bus_we_next     = bus_we_reg;
        bus_sel_next    = bus_sel_reg;
        bus_addr_next   = bus_addr_reg;
        bus_wdata_next  = bus_wdata_reg;
        if_rdata_next   = if_rdata_reg;
        if_ready_next   = 1'b0;
        dm_rdata_next   = dm_rdata_reg;
        dm_ready_next   = 1'b0;
        bus_err_next    = 1'b0;

        // DM wins when it is the only requester, or when both request and
        // IF was the master granted last.
        grant_dm     = dm_req && (!if_req || (last_grant_reg == GRANT_IF));
        serving_dm   = (state_reg == DM_BUS);
        wait_expired = (wait_cnt_reg == WAIT_LAST);

        case (state_reg)
            IDLE: begin
                if (grant_dm) begin
                    state_next     = DM_BUS;
                    bus_req_next   = 1'b1;
                    bus_we_next    = dm_we;
                    bus_sel_next   = dm_sel;
                    bus_addr_next  = dm_addr;
                    bus_wdata_next = dm_wdata;
                    wait_cnt_next  = 8'd0;
                end else if (if_req) begin
                    state_next     = IF_BUS;
                    bus_req_next   = 1'b1;
                    bus_we_next    = 1'b0;
                    bus_sel_next   = 4'hF;
                    bus_addr_next  = if_addr;
                    bus_wdata_next = 32'd0;
                    wait_cnt_next  = 8'd0;
                end
            end

            IF_BUS, DM_BUS: begin
                // bus_ack takes priority over the abort, so an ack that
                // arrives in the last allowed cycle still completes normally.
                if (bus_ack) begin
                    state_next      = DONE;
                    bus_req_next    = 1'b0;
                    last_grant_next = serving_dm ? GRANT_DM : GRANT_IF;
                    if (serving_dm) begin
                        dm_ready_next = 1'b1;
                        dm_rdata_next = bus_we_reg ? 32'd0 : bus_rdata;
                    end else begin
                        if_ready_next = 1'b1;
                        if_rdata_next = bus_rdata;
                    end
                end else if (wait_expired) begin
                    // The aborted master still counts as served, so a
                    // master on a dead address cannot starve the other one.
                    state_next      = DONE;
                    bus_req_next    = 1'b0;
                    bus_err_next    = 1'b1;
                    last_grant_next = serving_dm ? GRANT_DM : GRANT_IF;
                    if (serving_dm) begin
                        dm_ready_next = 1'b1;
                        dm_rdata_next = 32'd0;
                    end else begin
                        if_ready_next = 1'b1;
                        if_rdata_next = 32'd0;
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end

            DONE: begin
                // The masters still hold their requests during the ready
                // cycle. DONE ignores them so the same access is not issued
                // a second time.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    assign if_rdata  = if_rdata_reg;
    assign if_ready  = if_ready_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign dm_ready  = dm_ready_reg;
    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_sel   = bus_sel_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign bus_err   = bus_err_reg;
    assign busy      = busy_reg;

endmodule
